seg7_pattern_receiver: RTL and testbench
========================================

Name: seg7_pattern_receiver

Overview:
Receive end of the team's 7-segment drive path: samples seven segment lines (looped back from the PMOD header or probed from another board), synchronizes and de-glitches them, and decodes the displayed pattern back to a hex nibble. Flags patterns outside the hex glyph set. Checks that a counting display advances by +1 mod 16 per update. Used as an on-board self-checker for the display counter designs.

Parameters:
STABLE_CYCLES, 250, consecutive identical synchronized samples required before a pattern is accepted (legal range 2..65535); 10 us at 25 MHz
ACTIVE_LOW, 0, 1 = input lines are active-low (inverted immediately after synchronizer)
CHECK_STEP, 1, 1 = enable +1 sequence checking; 0 = o_Step_Error tied 0

Ports:
i_Clk  in  1  system clock (25 MHz)
i_Reset  in  1  asynchronous, active-high reset
i_Segments  in  7  raw segment lines, bit0 = A ... bit6 = G, asynchronous to i_Clk
o_Nibble  out  4  last accepted valid digit
o_Valid  out  1  level: last accepted pattern is a legal hex glyph
o_Blank  out  1  level: last accepted pattern is all segments off
o_Update  out  1  1-cycle pulse: newly accepted pattern differs from previous accepted pattern
o_Pattern_Error  out  1  1-cycle pulse with o_Update when the new pattern is neither a glyph nor blank
o_Step_Error  out  1  1-cycle pulse with o_Update when a valid digit does not equal previous valid digit + 1 mod 16
o_Update_Count  out  16  number of o_Update pulses, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release): synchronizer flops, stable counter and accepted pattern = 7'h00 (blank after polarity correction); o_Nibble=0, o_Valid=0, o_Blank=1, all pulses 0, o_Update_Count=0, FSM = S_SETTLE, step history invalid.
- Input path: 2-flop synchronizer per bit, then XOR with {7{ACTIVE_LOW}}; result = samp.
- Stability counter (16 bit): reset to 0 whenever samp != samp_prev; otherwise increments, holding at STABLE_CYCLES-1.
- FSM states:
  - S_SETTLE: waits for counter == STABLE_CYCLES-1.
    - If samp == accepted pattern: go to S_HOLD, no pulse.
    - Else: go to S_ACCEPT.
  - S_ACCEPT (one cycle): register the pattern; update o_Nibble/o_Valid/o_Blank; pulse o_Update plus error pulses as applicable; increment o_Update_Count; go to S_HOLD.
  - S_HOLD: any samp change returns to S_SETTLE. Outputs hold their values.
- Latency: a clean input change first sampled at edge 0 produces o_Update high in the cycle after edge STABLE_CYCLES+3.
- Glitch rule: any change shorter than STABLE_CYCLES samples never produces o_Update.
- Decode table (GFEDCBA, 1 = lit):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Blank (00): o_Valid=0, o_Blank=1, no error, o_Nibble holds, step history invalidated.
- Illegal pattern: o_Valid=0, o_Blank=0, o_Pattern_Error pulse, o_Nibble holds, step history invalidated.
- Step check: performed only when the previous accepted pattern was valid. The first valid digit after reset, blank, or error is never a step error. Wrap F->0 is legal. On error, history is still updated to the new digit.
- o_Update_Count stays at FFFF once reached.
- Reset asserted mid-S_ACCEPT: outputs clear immediately; no pulse is emitted.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant.
  - 16-entry glyph table constant (shared with the nibble-to-7SD encoder so both ends use one source).
  - FSM state enum {S_SETTLE, S_ACCEPT, S_HOLD}.
- Sub-module seg7_sync_filter (synchronizer + polarity + stability counter, outputs samp and stable flag). Decode and FSM stay in the top module.

Test Plan:
- Reset; hold i_Segments=06, STABLE_CYCLES=4 -> one o_Update at cycle 7 after first sample. Outputs: o_Nibble=1, o_Valid=1, o_Blank=0, no error pulses, count=1.
- Drive 3F,06,5B,...,71,3F, each held 10 cycles -> 17 o_Update pulses, o_Nibble follows 0..F,0, o_Step_Error never set, count=17.
- From accepted 4 (66), drive 3-cycle glitch to 6D, then back to 66 -> no o_Update; o_Nibble stays 4.
- Sequence 2 (5B) then 5 (6D) -> o_Update with o_Step_Error=1. Then 6 (7D) -> o_Update, no step error.
- Drive 7'h55 -> o_Pattern_Error + o_Update, o_Valid=0, o_Nibble holds. Next 3 (4F) -> o_Valid=1, no step error. Drive 00 -> o_Blank=1, no error.
- ACTIVE_LOW=1, drive ~7'h7F -> o_Nibble=8. Assert i_Reset mid-settle -> all outputs at reset values the same cycle. Force 70000 updates -> count = FFFF.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph table (GFEDCBA, 1 = lit), receiver FSM states
// and a pattern-to-nibble decode helper used by both ends of the display path.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [0:15][6:0] SEG_GLYPHS = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_ACCEPT = 2'd1,
        S_HOLD   = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] nibble;
    } glyph_match_t;

    function automatic glyph_match_t seg_decode(input logic [6:0] pattern);
        glyph_match_t m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_GLYPHS[i] == pattern) begin
                m.hit    = 1'b1;
                m.nibble = 4'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Brings the asynchronous segment lines into clk domain, corrects polarity and
// reports when the corrected sample has been steady for STABLE_CYCLES samples.
module seg7_sync_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 250,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_Segments,
    output logic [6:0] o_Samp,
    output logic       o_Stable
);

    // Flops reset to the level that reads as "all segments off" after inversion.
    localparam logic [6:0]  SYNC_RST    = {7{ACTIVE_LOW}};
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

    logic [6:0]  sync_meta;
    logic [6:0]  sync_q;
    logic [6:0]  samp_prev;
    logic [15:0] stable_cnt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync_meta  <= SYNC_RST;
            sync_q     <= SYNC_RST;
            samp_prev  <= SEG_BLANK;
            stable_cnt <= '0;
        end else begin
            sync_meta <= i_Segments;
            sync_q    <= sync_meta;
            samp_prev <= o_Samp;
            if (o_Samp != samp_prev)
                stable_cnt <= '0;
            else if (stable_cnt != STABLE_LAST)
                stable_cnt <= stable_cnt + 16'd1;
        end
    end

    assign o_Samp = sync_q ^ {7{ACTIVE_LOW}};

    // A change landing on the terminal-count cycle must not be accepted as stable.
    assign o_Stable = (stable_cnt == STABLE_LAST) && (o_Samp == samp_prev);

endmodule

// File: rtl/seg7_pattern_receiver.sv
// Decodes a de-glitched 7-segment pattern back to a hex nibble and checks +1 stepping.
// state    | meaning
// S_SETTLE | waiting for the filtered sample to be stable
// S_ACCEPT | one cycle: commit candidate, update outputs, pulse o_Update
// S_HOLD   | pattern accepted; any sample change returns to S_SETTLE
module seg7_pattern_receiver
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 250,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter bit          CHECK_STEP    = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [6:0]  i_Segments,
    output logic [3:0]  o_Nibble,
    output logic        o_Valid,
    output logic        o_Blank,
    output logic        o_Update,
    output logic        o_Pattern_Error,
    output logic        o_Step_Error,
    output logic [15:0] o_Update_Count
);

    rx_state_t    state_q;
    rx_state_t    state_nxt;
    logic [6:0]   samp;
    logic         stable;
    logic [6:0]   cand_q;
    logic [6:0]   pattern_q;
    logic [15:0]  update_count_q;
    logic         capture;
    logic         accept;
    glyph_match_t cand_match;
    logic         cand_blank;
    logic         step_bad;

    seg7_sync_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_sync_filter (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Segments (i_Segments),
        .o_Samp     (samp),
        .o_Stable   (stable)
    );

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            state_q <= S_SETTLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_SETTLE: begin
                if (stable) begin
                    if (samp == pattern_q) begin
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_ACCEPT;
                        capture   = 1'b1;
                    end
                end
            end
            S_ACCEPT: begin
                accept    = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (samp != pattern_q)
                    state_nxt = S_SETTLE;
            end
            default: state_nxt = S_SETTLE;
        endcase
    end

    // The candidate is latched when stability is seen so a late change cannot leak in.
    assign cand_match = seg_decode(cand_q);
    assign cand_blank = (cand_q == SEG_BLANK);
    assign step_bad   = CHECK_STEP && o_Valid && (cand_match.nibble != (o_Nibble + 4'd1));

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cand_q          <= SEG_BLANK;
            pattern_q       <= SEG_BLANK;
            o_Nibble        <= 4'h0;
            o_Valid         <= 1'b0;
            o_Blank         <= 1'b1;
            o_Update        <= 1'b0;
            o_Pattern_Error <= 1'b0;
            o_Step_Error    <= 1'b0;
            update_count_q  <= '0;
        end else begin
            o_Update        <= 1'b0;
            o_Pattern_Error <= 1'b0;
            o_Step_Error    <= 1'b0;
            if (capture)
                cand_q <= samp;
            if (accept) begin
                pattern_q <= cand_q;
                o_Update  <= 1'b1;
                if (update_count_q != 16'hFFFF)
                    update_count_q <= update_count_q + 16'd1;
                if (cand_blank) begin
                    o_Valid <= 1'b0;
                    o_Blank <= 1'b1;
                end else if (cand_match.hit) begin
                    o_Nibble     <= cand_match.nibble;
                    o_Valid      <= 1'b1;
                    o_Blank      <= 1'b0;
                    o_Step_Error <= step_bad;
                end else begin
                    o_Valid         <= 1'b0;
                    o_Blank         <= 1'b0;
                    o_Pattern_Error <= 1'b1;
                end
            end
        end
    end

    assign o_Update_Count = update_count_q;

endmodule

// File: tb/tb_seg7_pattern_receiver.sv
// Directed bench for seg7_pattern_receiver with STABLE_CYCLES=4, plus an active-low instance.
module tb_seg7_pattern_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [6:0]  seg;
    logic [6:0]  seg2;
    logic [3:0]  nib,  nib2;
    logic        valid, valid2;
    logic        blank, blank2;
    logic        upd,  upd2;
    logic        perr, perr2;
    logic        serr, serr2;
    logic [15:0] cnt,  cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_seen = 0;
    int perr_seen = 0;
    int serr_seen = 0;
    int u0, p0, s0;

    always #5 clk = ~clk;

    seg7_pattern_receiver #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0), .CHECK_STEP(1'b1)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Segments(seg),
        .o_Nibble(nib), .o_Valid(valid), .o_Blank(blank), .o_Update(upd),
        .o_Pattern_Error(perr), .o_Step_Error(serr), .o_Update_Count(cnt)
    );

    seg7_pattern_receiver #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1), .CHECK_STEP(1'b1)) dut_al (
        .i_Clk(clk), .i_Reset(rst2), .i_Segments(seg2),
        .o_Nibble(nib2), .o_Valid(valid2), .o_Blank(blank2), .o_Update(upd2),
        .o_Pattern_Error(perr2), .o_Step_Error(serr2), .o_Update_Count(cnt2)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (upd)  upd_seen++;
            if (perr) perr_seen++;
            if (serr) serr_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [6:0] p, input int cycles);
        seg = p;
        repeat (cycles) @(negedge clk);
    endtask

    localparam logic [6:0] SEQ [17] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F
    };

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        seg  = 7'h06;
        seg2 = 7'h7F;
        #1;
        chk("rst_nibble", 32'(nib), 32'h0);
        chk("rst_valid",  32'(valid), 32'h0);
        chk("rst_blank",  32'(blank), 32'h1);
        chk("rst_update", 32'(upd), 32'h0);
        chk("rst_count",  32'(cnt), 32'h0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        rst2 = 1'b0;

        // Latency: first sample at edge 0, update visible after edge 7
        repeat (7) @(negedge clk);
        chk("lat_early_update", 32'(upd), 32'h0);
        @(negedge clk);
        chk("lat_update", 32'(upd), 32'h1);
        chk("lat_nibble", 32'(nib), 32'h1);
        chk("lat_valid",  32'(valid), 32'h1);
        chk("lat_blank",  32'(blank), 32'h0);
        chk("lat_perr",   32'(perr), 32'h0);
        chk("lat_serr",   32'(serr), 32'h0);
        chk("lat_count",  32'(cnt), 32'h1);
        @(negedge clk);
        chk("lat_pulse_width", 32'(upd), 32'h0);

        // Active-low instance: all lines low means every segment lit -> 8
        chk("al_idle_blank", 32'(blank2), 32'h1);
        seg2 = 7'h00;
        repeat (12) @(negedge clk);
        chk("al_nibble", 32'(nib2), 32'h8);
        chk("al_valid",  32'(valid2), 32'h1);
        chk("al_blank",  32'(blank2), 32'h0);
        chk("al_count",  32'(cnt2), 32'h1);

        // Full counting sequence from blank, including the F->0 wrap
        hold(7'h00, 10);
        chk("seq_blank", 32'(blank), 32'h1);
        u0 = upd_seen;
        s0 = serr_seen;
        for (int i = 0; i < 17; i++) begin
            hold(SEQ[i], 10);
            chk("seq_nibble", 32'(nib), 32'(i % 16));
        end
        chk("seq_updates", 32'(upd_seen - u0), 32'd17);
        chk("seq_step_errors", 32'(serr_seen - s0), 32'd0);
        chk("seq_count", 32'(cnt), 32'd19);

        // Short glitch away from an accepted pattern is ignored
        hold(7'h66, 10);
        u0 = upd_seen;
        hold(7'h6D, 3);
        hold(7'h66, 10);
        chk("glitch_updates", 32'(upd_seen - u0), 32'd0);
        chk("glitch_nibble", 32'(nib), 32'h4);

        // Step error 2 -> 5, then 5 -> 6 clean
        hold(7'h5B, 10);
        s0 = serr_seen;
        hold(7'h6D, 10);
        chk("step_err_count", 32'(serr_seen - s0), 32'd1);
        chk("step_err_nibble", 32'(nib), 32'h5);
        s0 = serr_seen;
        u0 = upd_seen;
        hold(7'h7D, 10);
        chk("step_ok_count", 32'(serr_seen - s0), 32'd0);
        chk("step_ok_update", 32'(upd_seen - u0), 32'd1);
        chk("step_ok_nibble", 32'(nib), 32'h6);

        // Illegal pattern, recovery without step error, then blank
        p0 = perr_seen;
        u0 = upd_seen;
        hold(7'h55, 10);
        chk("illegal_perr", 32'(perr_seen - p0), 32'd1);
        chk("illegal_update", 32'(upd_seen - u0), 32'd1);
        chk("illegal_valid", 32'(valid), 32'h0);
        chk("illegal_blank", 32'(blank), 32'h0);
        chk("illegal_nibble", 32'(nib), 32'h6);
        s0 = serr_seen;
        hold(7'h4F, 10);
        chk("recover_valid", 32'(valid), 32'h1);
        chk("recover_nibble", 32'(nib), 32'h3);
        chk("recover_serr", 32'(serr_seen - s0), 32'd0);
        p0 = perr_seen;
        hold(7'h00, 10);
        chk("blank_blank", 32'(blank), 32'h1);
        chk("blank_valid", 32'(valid), 32'h0);
        chk("blank_nibble", 32'(nib), 32'h3);
        chk("blank_perr", 32'(perr_seen - p0), 32'd0);

        // Reset mid-settle clears outputs immediately
        hold(7'h06, 3);
        rst = 1'b1;
        #1;
        chk("rst_mid_nibble", 32'(nib), 32'h0);
        chk("rst_mid_valid",  32'(valid), 32'h0);
        chk("rst_mid_blank",  32'(blank), 32'h1);
        chk("rst_mid_count",  32'(cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset landing in the accept cycle emits no pulse
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_acc_update", 32'(upd), 32'h0);
        chk("rst_acc_count",  32'(cnt), 32'h0);
        @(negedge clk);
        chk("rst_acc_update2", 32'(upd), 32'h0);
        chk("rst_acc_valid",   32'(valid), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_nibble", 32'(nib), 32'h1);
        chk("post_rst_count",  32'(cnt), 32'h1);

        // Counter saturation, preloaded near the top
        force dut.update_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.update_count_q;
        @(negedge clk);
        chk("sat_preload", 32'(cnt), 32'hFFFE);
        hold(7'h5B, 10);
        chk("sat_reach", 32'(cnt), 32'hFFFF);
        hold(7'h4F, 10);
        chk("sat_hold", 32'(cnt), 32'hFFFF);
        chk("sat_nibble", 32'(nib), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
